// File: rtl/lcd_bus_responder_if.sv
// HD44780-style 8-bit LCD bus between controller (master)
// and the on-chip responder (slave).
interface lcd_bus_responder_if #(
  parameter int SIZE_DATA = 8
);
  logic [SIZE_DATA-1:0] i_LCD_DATA;
  logic                 i_LCD_E;
  logic                 i_LCD_RW;
  logic                 i_LCD_RS;
  logic                 i_LCD_ON;
  logic [SIZE_DATA-1:0] o_LCD_DATA;
  logic                 o_LCD_DATA_OE;

  modport master (
    output i_LCD_DATA,
    output i_LCD_E,
    output i_LCD_RW,
    output i_LCD_RS,
    output i_LCD_ON,
    input  o_LCD_DATA,
    input  o_LCD_DATA_OE
  );

  modport slave (
    input  i_LCD_DATA,
    input  i_LCD_E,
    input  i_LCD_RW,
    input  i_LCD_RS,
    input  i_LCD_ON,
    output o_LCD_DATA,
    output o_LCD_DATA_OE
  );
endinterface

// File: rtl/lcd_bus_responder.sv
// LCD bus responder: decodes E/RS/RW cycles, models DDRAM,
// address counter, entry mode, display-on and busy flag.
module lcd_bus_responder #(
  parameter int SIZE_DATA    = 8,
  parameter int BUSY_CYC_CMD = 2000,
  parameter int BUSY_CYC_CLR = 82000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  lcd_bus_responder_if.slave   bus,
  output logic                 o_wr_valid,
  output logic                 o_wr_rs,
  output logic [SIZE_DATA-1:0] o_wr_data,
  output logic [6:0]           o_ddram_addr,
  output logic                 o_busy,
  output logic                 o_disp_on,
  output logic                 o_proto_err
);
  localparam int CW = $clog2(BUSY_CYC_CLR + 1);
  localparam logic [CW-1:0] N_CMD = CW'(BUSY_CYC_CMD);
  localparam logic [CW-1:0] N_CLR = CW'(BUSY_CYC_CLR);
  localparam logic [SIZE_DATA-1:0] BLANK =
    SIZE_DATA'(8'h20);

  typedef enum logic {
    CLR_IDLE,
    CLR_FILL
  } clr_st_e;

  logic                 e_q, rs_q, rw_q;
  logic [SIZE_DATA-1:0] data_q;
  logic [CW-1:0]        busy_cnt_q, busy_cnt_d;
  logic [6:0]           addr_q, addr_d;
  logic                 id_q, id_d;
  logic                 disp_q, disp_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 wr_rs_q, wr_rs_d;
  logic [SIZE_DATA-1:0] wr_data_q, wr_data_d;
  logic                 err_q, err_d;
  logic                 oe_q, oe_d;
  logic [SIZE_DATA-1:0] rdata_q, rdata_d;
  clr_st_e              clr_st_q, clr_st_d;
  logic [6:0]           clr_idx_q, clr_idx_d;

  logic [SIZE_DATA-1:0] mem [0:127];
  logic                 mem_we;
  logic [6:0]           mem_wa;
  logic [SIZE_DATA-1:0] mem_wd;

  logic busy;
  logic fall;

  assign busy = (busy_cnt_q != '0);
  assign fall = e_q & ~bus.i_LCD_E & bus.i_LCD_ON;

  // Two display lines: 0x00-0x27 and 0x40-0x67 wrap into each other
  function automatic logic [6:0] step_addr(
    input logic [6:0] a,
    input logic       inc
  );
    logic [6:0] r;
    if (inc) begin
      unique case (a)
        7'h27:   r = 7'h40;
        7'h67:   r = 7'h00;
        default: r = a + 7'd1;
      endcase
    end else begin
      unique case (a)
        7'h40:   r = 7'h27;
        7'h00:   r = 7'h67;
        default: r = a - 7'd1;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    busy_cnt_d = busy_cnt_q - CW'(busy);
    addr_d     = addr_q;
    id_d       = id_q;
    disp_d     = disp_q;
    wr_valid_d = 1'b0;
    wr_rs_d    = wr_rs_q;
    wr_data_d  = wr_data_q;
    err_d      = 1'b0;
    clr_st_d   = clr_st_q;
    clr_idx_d  = clr_idx_q;
    mem_we     = 1'b0;
    mem_wa     = addr_q;
    mem_wd     = data_q;
    oe_d       = bus.i_LCD_E & bus.i_LCD_RW &
                 bus.i_LCD_ON;
    rdata_d    = bus.i_LCD_RS ? mem[addr_q] :
                 SIZE_DATA'({busy, addr_q});

    // Blank fill overlaps the busy window, so it never
    // collides with an accepted data write.
    unique case (clr_st_q)
      CLR_FILL: begin
        mem_we    = 1'b1;
        mem_wa    = clr_idx_q;
        mem_wd    = BLANK;
        clr_idx_d = clr_idx_q + 7'd1;
        if (clr_idx_q == 7'h7F) clr_st_d = CLR_IDLE;
      end
      default: begin
      end
    endcase

    if (fall) begin
      if (!rw_q) begin
        if (busy) begin
          err_d = 1'b1;
        end else begin
          wr_valid_d = 1'b1;
          wr_rs_d    = rs_q;
          wr_data_d  = data_q;
          busy_cnt_d = N_CMD;
          if (rs_q) begin
            mem_we = 1'b1;
            mem_wa = addr_q;
            mem_wd = data_q;
            addr_d = step_addr(addr_q, id_q);
          end else begin
            unique case (1'b1)
              data_q[7]: addr_d = data_q[6:0];
              (data_q[7:3] == 5'b00001):
                disp_d = data_q[2];
              (data_q[7:2] == 6'b000001):
                id_d = data_q[1];
              (data_q[7:1] == 7'b0000001): begin
                addr_d     = '0;
                busy_cnt_d = N_CLR;
              end
              (data_q[7:0] == 8'h01): begin
                addr_d     = '0;
                id_d       = 1'b1;
                busy_cnt_d = N_CLR;
                clr_st_d   = CLR_FILL;
                clr_idx_d  = '0;
              end
              default: begin
              end
            endcase
          end
        end
      end else if (rs_q) begin
        if (busy) err_d = 1'b1;
        else addr_d = step_addr(addr_q, id_q);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      data_q     <= '0;
      busy_cnt_q <= '0;
      addr_q     <= '0;
      id_q       <= 1'b1;
      disp_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_rs_q    <= 1'b0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      oe_q       <= 1'b0;
      rdata_q    <= '0;
      clr_st_q   <= CLR_IDLE;
      clr_idx_q  <= '0;
    end else begin
      e_q        <= bus.i_LCD_E;
      rs_q       <= bus.i_LCD_RS;
      rw_q       <= bus.i_LCD_RW;
      data_q     <= bus.i_LCD_DATA;
      busy_cnt_q <= busy_cnt_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      disp_q     <= disp_d;
      wr_valid_q <= wr_valid_d;
      wr_rs_q    <= wr_rs_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
      oe_q       <= oe_d;
      rdata_q    <= rdata_d;
      clr_st_q   <= clr_st_d;
      clr_idx_q  <= clr_idx_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign o_wr_valid        = wr_valid_q;
  assign o_wr_rs           = wr_rs_q;
  assign o_wr_data         = wr_data_q;
  assign o_ddram_addr      = addr_q;
  assign o_busy            = busy;
  assign o_disp_on         = disp_q;
  assign o_proto_err       = err_q;
  assign bus.o_LCD_DATA    = rdata_q;
  assign bus.o_LCD_DATA_OE = oe_q;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: directed and random bus
// cycles against a cycle-numbered behavioural LCD model.
module tb_lcd_bus_responder;
  localparam int NCMD = 4;
  localparam int NCLR = 130;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_bus_responder_if #(.SIZE_DATA(8)) bus ();

  logic       wr_valid, wr_rs, busy, disp_on, proto_err;
  logic [7:0] wr_data;
  logic [6:0] ddram_addr;

  lcd_bus_responder #(
    .SIZE_DATA   (8),
    .BUSY_CYC_CMD(NCMD),
    .BUSY_CYC_CLR(NCLR)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_wr_valid  (wr_valid),
    .o_wr_rs     (wr_rs),
    .o_wr_data   (wr_data),
    .o_ddram_addr(ddram_addr),
    .o_busy      (busy),
    .o_disp_on   (disp_on),
    .o_proto_err (proto_err)
  );

  // model: posedge count, busy window ends at busy_end
  int         cyc = 0;
  int         busy_end = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] mem_m [128];
  bit         known [128];
  logic [6:0] addr_m = '0;
  bit         id_m = 1'b1;
  bit         disp_m = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] nxt(input logic [6:0] a,
                                     input bit inc);
    int v;
    if (inc) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      v = (int'(a) + 1) % 128;
    end else begin
      if (a == 7'h40) return 7'h27;
      if (a == 7'h00) return 7'h67;
      v = (int'(a) + 127) % 128;
    end
    return 7'(v);
  endfunction

  task automatic apply_instr(input logic [7:0] d,
                             input int c);
    int n;
    n = NCMD;
    if (d[7]) addr_m = d[6:0];
    else if (d[7:6] == 2'b01) n = NCMD;
    else if (d[7:5] == 3'b001) n = NCMD;
    else if (d[7:4] == 4'b0001) n = NCMD;
    else if (d[7:3] == 5'b00001) disp_m = d[2];
    else if (d[7:2] == 6'b000001) id_m = d[1];
    else if (d[7:1] == 7'b0000001) begin
      addr_m = '0;
      n = NCLR;
    end else if (d == 8'h01) begin
      addr_m = '0;
      id_m = 1'b1;
      n = NCLR;
      for (int i = 0; i < 128; i++) begin
        mem_m[i] = 8'h20;
        known[i] = 1'b1;
      end
    end
    busy_end = c + n;
  endtask

  task automatic do_write(input bit rs,
                          input logic [7:0] d);
    int c;
    bit acc;
    bus.i_LCD_RS   = rs;
    bus.i_LCD_RW   = 1'b0;
    bus.i_LCD_DATA = d;
    bus.i_LCD_E    = 1'b1;
    @(negedge clk);
    bus.i_LCD_E = 1'b0;
    @(negedge clk);
    c = cyc;
    acc = (c > busy_end);
    chk("wr_valid", wr_valid, acc);
    chk("proto_err", proto_err, !acc);
    if (acc) begin
      chk("wr_rs", wr_rs, rs);
      chk("wr_data", wr_data, d);
      if (rs) begin
        mem_m[addr_m] = d;
        known[addr_m] = 1'b1;
        addr_m = nxt(addr_m, id_m);
        busy_end = c + NCMD;
      end else begin
        apply_instr(d, c);
      end
    end
    chk("addr", ddram_addr, addr_m);
    chk("busy", busy, c < busy_end);
    chk("disp_on", disp_on, disp_m);
  endtask

  task automatic do_read(input bit rs);
    int  k;
    bit  fb;
    bus.i_LCD_RS = rs;
    bus.i_LCD_RW = 1'b1;
    bus.i_LCD_E  = 1'b1;
    @(negedge clk);
    k = cyc;
    fb = (k + 1) <= busy_end;
    chk("oe_on", bus.o_LCD_DATA_OE, 1);
    if (!rs)
      chk("bf_read", bus.o_LCD_DATA,
          {((k - 1) < busy_end), addr_m});
    else if (!fb && known[addr_m])
      chk("dd_read", bus.o_LCD_DATA, mem_m[addr_m]);
    bus.i_LCD_E = 1'b0;
    @(negedge clk);
    chk("oe_off", bus.o_LCD_DATA_OE, 0);
    chk("rd_err", proto_err, rs && fb);
    chk("rd_no_wr", wr_valid, 0);
    if (rs && !fb) addr_m = nxt(addr_m, id_m);
    chk("rd_addr", ddram_addr, addr_m);
  endtask

  task automatic wait_idle();
    while (cyc + 2 <= busy_end) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.i_LCD_E    = 1'b0;
    bus.i_LCD_RW   = 1'b0;
    bus.i_LCD_RS   = 1'b0;
    bus.i_LCD_DATA = '0;
    @(negedge clk);
    busy_end = cyc;
    addr_m = '0;
    id_m = 1'b1;
    disp_m = 1'b0;
    for (int i = 0; i < 128; i++) known[i] = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_addr", ddram_addr, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_err", proto_err, 0);
    chk("rst_disp", disp_on, 0);
    chk("rst_oe", bus.o_LCD_DATA_OE, 0);
    chk("rst_rdata", bus.o_LCD_DATA, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic measure_busy(input int exp_n,
                              input string tag);
    int n;
    n = 0;
    while (busy && n < exp_n + 10) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, exp_n);
  endtask

  initial begin
    int         op;
    int         c0;
    logic [7:0] r;
    bus.i_LCD_ON   = 1'b1;
    bus.i_LCD_E    = 1'b0;
    bus.i_LCD_RW   = 1'b0;
    bus.i_LCD_RS   = 1'b0;
    bus.i_LCD_DATA = '0;
    repeat (3) @(negedge clk);
    do_reset();

    // display on, short busy window
    do_write(1'b0, 8'h0C);
    measure_busy(NCMD, "busy_len_cmd");
    chk("disp_after_0C", disp_on, 1);

    // line wrap 0x27->0x40, 0x67->0x00
    wait_idle(); do_write(1'b0, 8'hA7);
    wait_idle(); do_write(1'b1, 8'h41);
    chk("wrap_27", ddram_addr, 7'h40);
    wait_idle(); do_write(1'b0, 8'hA7);
    wait_idle(); do_read(1'b1);
    wait_idle(); do_write(1'b0, 8'hE7);
    wait_idle(); do_write(1'b1, 8'($urandom));
    chk("wrap_67", ddram_addr, 7'h00);

    // decrement wrap 0x40->0x27
    wait_idle(); do_write(1'b0, 8'h04);
    wait_idle(); do_write(1'b0, 8'hC0);
    wait_idle(); do_write(1'b1, 8'($urandom));
    chk("wrap_40_dec", ddram_addr, 7'h27);

    // clear with busy-flag polling
    wait_idle(); do_write(1'b0, 8'h01);
    c0 = cyc;
    repeat (5) do_read(1'b0);
    while (busy && cyc - c0 < NCLR + 20)
      @(negedge clk);
    chk("busy_len_clr", cyc - c0, NCLR);
    wait_idle(); do_write(1'b0, 8'h90);
    wait_idle(); do_read(1'b1);

    // writes while busy, incl. last busy cycle
    wait_idle(); do_write(1'b0, 8'h85);
    wait_idle(); do_write(1'b1, 8'h11);
    do_write(1'b1, 8'h22);
    wait_idle(); do_write(1'b0, 8'h86);
    wait_idle(); do_read(1'b1);
    wait_idle(); do_write(1'b1, 8'h33);
    repeat (2) @(negedge clk);
    do_write(1'b1, 8'h44);
    do_write(1'b1, 8'h55);
    repeat (3) @(negedge clk);
    do_write(1'b1, 8'h66);
    do_read(1'b1);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      r = 8'($urandom);
      if ($urandom_range(0, 3) != 0) wait_idle();
      case (op)
        0, 1: do_write(1'b1, r);
        2: do_write(1'b0, {1'b1, r[6:0]});
        3: do_write(1'b0, {6'b000001, r[1:0]});
        4: do_write(1'b0, {5'b00001, r[2:0]});
        5: do_write(1'b0, {2'b01, r[5:0]});
        6: do_read(1'b0);
        7, 8: do_read(1'b1);
        default:
          if (r[0]) do_write(1'b0, {7'b0000001, r[1]});
          else do_write(1'b0, {3'b001, r[4:0]});
      endcase
    end

    // module powered off: bus ignored
    wait_idle();
    bus.i_LCD_ON   = 1'b0;
    bus.i_LCD_RS   = 1'b1;
    bus.i_LCD_RW   = 1'b0;
    bus.i_LCD_DATA = 8'h5A;
    bus.i_LCD_E    = 1'b1;
    @(negedge clk);
    bus.i_LCD_E = 1'b0;
    @(negedge clk);
    chk("off_wr_valid", wr_valid, 0);
    chk("off_err", proto_err, 0);
    chk("off_addr", ddram_addr, addr_m);
    bus.i_LCD_RW = 1'b1;
    bus.i_LCD_E  = 1'b1;
    @(negedge clk);
    chk("off_oe", bus.o_LCD_DATA_OE, 0);
    bus.i_LCD_E = 1'b0;
    @(negedge clk);
    bus.i_LCD_ON = 1'b1;
    @(negedge clk);

    // reset in the middle of a clear
    wait_idle(); do_write(1'b0, 8'h01);
    repeat (40) @(negedge clk);
    do_reset();
    do_write(1'b1, 8'($urandom));
    chk("post_rst_addr", ddram_addr, 7'h01);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
